cci_mpf_chan_checker: RTL and testbench

Parametrised per-channel protocol checker for MPF's CCI request/response channels. Generalises the existing unclocked X-checks to N request channels with cycle-accurate tracking: outstanding line counts, almost-full slack enforcement and response underflow detection. Instantiated passively beside any MPF shim boundary and driven only from monitor-direction signals. Simulation and synthesis behaviour are identical, so errors can also drive a debug CSR.

---
 rtl/cci_mpf_chan_checker_pkg.sv | 47 ++++
 rtl/cci_mpf_chan_checker_if.sv | 23 ++
 rtl/cci_mpf_chan_checker_lane.sv | 136 +++++++++++++
 rtl/cci_mpf_chan_checker.sv | 103 ++++++++++
 tb/tb_cci_mpf_chan_checker.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cci_mpf_chan_checker_pkg.sv
// Shared types and the outstanding-count arithmetic for the MPF channel checker.
package cci_mpf_chan_checker_pkg;

    // Per-channel almost-full tracking states.
    typedef enum logic [1:0] {
        OK       = 2'd0,
        THROTTLE = 2'd1,
        VIOL     = 2'd2
    } t_chk_state;

    // One bit per error class raised by a channel.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic almfull;
    } t_err_vec;

    // Next outstanding count. Requests add (lines+1); a response removes one
    // line only when something is outstanding after the same-cycle add, so the
    // count never goes below zero. The result is clamped at sat_max.
    function automatic logic [31:0] f_next_cnt(
        input logic [31:0] cnt,
        input logic        tx_valid,
        input logic [1:0]  tx_lines,
        input logic        rx_valid,
        input logic [31:0] sat_max
    );
        logic [31:0] sum;
        if (tx_valid) begin
            sum = cnt + {30'd0, tx_lines} + 32'd1;
        end else begin
            sum = cnt;
        end
        if (rx_valid && (sum != 32'd0)) begin
            sum = sum - 32'd1;
        end else begin
            sum = sum;
        end
        if (sum > sat_max) begin
            sum = sat_max;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cci_mpf_chan_checker_if.sv
// Monitor-direction request/response signals of N CCI channels.
interface cci_mpf_chan_checker_if #(
    parameter int N_CHAN = 2
);
    logic [N_CHAN-1:0]   tx_valid;
    logic [2*N_CHAN-1:0] tx_lines;
    logic [N_CHAN-1:0]   tx_almfull;
    logic [N_CHAN-1:0]   rx_valid;

    modport master (
        output tx_valid,
        output tx_lines,
        output tx_almfull,
        output rx_valid
    );

    modport slave (
        input tx_valid,
        input tx_lines,
        input tx_almfull,
        input rx_valid
    );
endinterface

// File: rtl/cci_mpf_chan_checker_lane.sv
// Single-channel checker: outstanding-line counter, almost-full slack FSM and
// the channel's error bits. Exposes next-cycle values so the top level can
// register its summary outputs in step with the lane registers.
module cci_mpf_chan_checker_lane
    import cci_mpf_chan_checker_pkg::*;
#(
    parameter int CNT_W           = 10,
    parameter int MAX_OUTSTANDING = 512,
    parameter int ALMFULL_SLACK   = 8,
    parameter int STICKY_ERR      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tx_valid,
    input  logic [1:0]       i_tx_lines,
    input  logic             i_tx_almfull,
    input  logic             i_rx_valid,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output t_err_vec         o_err,
    output t_err_vec         o_err_nxt
);
    localparam logic [31:0] SAT_MAX = (32'd1 << CNT_W) - 32'd1;
    localparam logic [31:0] MAX_OUT = 32'(MAX_OUTSTANDING);
    localparam int          SLACK_W = $clog2(ALMFULL_SLACK + 2);
    localparam logic [SLACK_W-1:0] SLACK_LIM = SLACK_W'(ALMFULL_SLACK);

    logic [CNT_W-1:0]   r_cnt;
    t_chk_state         r_state;
    logic [SLACK_W-1:0] r_slack;
    t_err_vec           r_err;

    logic [31:0]        w_cnt32;
    logic [31:0]        w_next32;
    logic               w_uf_evt;
    logic               w_of_evt;
    logic               w_af_evt;
    t_chk_state         w_state_nxt;
    logic [SLACK_W-1:0] w_slack_nxt;
    logic [SLACK_W-1:0] w_slack_inc;
    t_err_vec           w_evt;
    t_err_vec           w_err_nxt;

    // Count update plus overflow/underflow event detection.
    always_comb begin
        w_cnt32  = 32'(r_cnt);
        w_next32 = f_next_cnt(w_cnt32, i_tx_valid, i_tx_lines, i_rx_valid, SAT_MAX);
        w_uf_evt = i_rx_valid && !i_tx_valid && (r_cnt == {CNT_W{1'b0}});
        // One overflow event per excursion above the limit, not one per cycle.
        w_of_evt = (w_next32 > MAX_OUT) && (w_cnt32 <= MAX_OUT);
    end

    // Almost-full FSM next state; a new episode starts its slack from zero.
    always_comb begin
        w_state_nxt = r_state;
        w_slack_nxt = r_slack;
        w_af_evt    = 1'b0;
        if (r_state == OK) begin
            w_slack_inc = SLACK_W'(i_tx_valid);
        end else begin
            w_slack_inc = r_slack + SLACK_W'(i_tx_valid);
        end
        case (r_state)
            OK: begin
                if (i_tx_almfull) begin
                    w_slack_nxt = w_slack_inc;
                    if (w_slack_inc > SLACK_LIM) begin
                        w_state_nxt = VIOL;
                        w_af_evt    = 1'b1;
                    end else begin
                        w_state_nxt = THROTTLE;
                    end
                end else begin
                    w_slack_nxt = {SLACK_W{1'b0}};
                end
            end
            THROTTLE: begin
                if (!i_tx_almfull) begin
                    w_state_nxt = OK;
                    w_slack_nxt = {SLACK_W{1'b0}};
                end else if (w_slack_inc > SLACK_LIM) begin
                    w_state_nxt = VIOL;
                    w_slack_nxt = w_slack_inc;
                    w_af_evt    = 1'b1;
                end else begin
                    w_slack_nxt = w_slack_inc;
                end
            end
            VIOL: begin
                if (!i_tx_almfull) begin
                    w_state_nxt = OK;
                    w_slack_nxt = {SLACK_W{1'b0}};
                end else begin
                    w_state_nxt = VIOL;
                end
            end
            default: begin
                w_state_nxt = OK;
                w_slack_nxt = {SLACK_W{1'b0}};
            end
        endcase
    end

    // Error bits either accumulate or mirror the current events.
    always_comb begin
        w_evt.overflow  = w_of_evt;
        w_evt.underflow = w_uf_evt;
        w_evt.almfull   = w_af_evt;
        if (STICKY_ERR != 0) begin
            w_err_nxt = t_err_vec'(r_err | w_evt);
        end else begin
            w_err_nxt = w_evt;
        end
    end

    // Lane state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= OK;
            r_slack <= {SLACK_W{1'b0}};
            r_err   <= 3'b000;
        end else begin
            r_cnt   <= w_next32[CNT_W-1:0];
            r_state <= w_state_nxt;
            r_slack <= w_slack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_next32[CNT_W-1:0];
    assign o_err     = r_err;
    assign o_err_nxt = w_err_nxt;

endmodule

// File: rtl/cci_mpf_chan_checker.sv
// Passive per-channel protocol checker for MPF CCI request/response channels.
// Lanes do the per-channel work; this level forms err_any, first_err_chan
// and idle, all registered alongside the lane registers.
module cci_mpf_chan_checker
    import cci_mpf_chan_checker_pkg::*;
#(
    parameter int N_CHAN          = 2,
    parameter int CNT_W           = 10,
    parameter int MAX_OUTSTANDING = 512,
    parameter int ALMFULL_SLACK   = 8,
    parameter int STICKY_ERR      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    cci_mpf_chan_checker_if.slave   i_bus,
    output logic [CNT_W*N_CHAN-1:0] o_outstanding,
    output logic [N_CHAN-1:0]       o_err_overflow,
    output logic [N_CHAN-1:0]       o_err_underflow,
    output logic [N_CHAN-1:0]       o_err_almfull,
    output logic                    o_err_any,
    output logic [2:0]              o_first_err_chan,
    output logic                    o_idle
);
    logic [CNT_W-1:0] w_cnt_nxt [N_CHAN];
    t_err_vec         w_err_nxt [N_CHAN];
    t_err_vec         w_err     [N_CHAN];

    logic       w_any_nxt;
    logic [2:0] w_first_idx;
    logic       w_all_zero;
    logic       w_idle_nxt;

    logic       r_err_any;
    logic [2:0] r_first_err_chan;
    logic       r_first_seen;
    logic       r_idle;

    for (genvar g = 0; g < N_CHAN; g++) begin : g_lane
        cci_mpf_chan_checker_lane #(
            .CNT_W           (CNT_W),
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .ALMFULL_SLACK   (ALMFULL_SLACK),
            .STICKY_ERR      (STICKY_ERR)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .i_tx_valid   (i_bus.tx_valid[g]),
            .i_tx_lines   (i_bus.tx_lines[2*g +: 2]),
            .i_tx_almfull (i_bus.tx_almfull[g]),
            .i_rx_valid   (i_bus.rx_valid[g]),
            .o_cnt        (o_outstanding[CNT_W*g +: CNT_W]),
            .o_cnt_nxt    (w_cnt_nxt[g]),
            .o_err        (w_err[g]),
            .o_err_nxt    (w_err_nxt[g])
        );
        assign o_err_overflow[g]  = w_err[g].overflow;
        assign o_err_underflow[g] = w_err[g].underflow;
        assign o_err_almfull[g]   = w_err[g].almfull;
    end

    // Summary terms from the lanes' next-cycle values; scanning downwards
    // leaves the lowest erroring channel index in w_first_idx.
    always_comb begin
        w_any_nxt   = 1'b0;
        w_first_idx = 3'd0;
        w_all_zero  = 1'b1;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (w_err_nxt[i] != 3'b000) begin
                w_any_nxt   = 1'b1;
                w_first_idx = 3'(i);
            end else begin
                w_any_nxt   = w_any_nxt;
            end
            w_all_zero = w_all_zero & (w_cnt_nxt[i] == {CNT_W{1'b0}});
        end
        w_idle_nxt = w_all_zero && (i_bus.tx_valid == {N_CHAN{1'b0}});
    end

    // Summary registers; first_err_chan is captured once per reset period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_any        <= 1'b0;
            r_first_err_chan <= 3'd0;
            r_first_seen     <= 1'b0;
            r_idle           <= 1'b1;
        end else begin
            r_err_any <= w_any_nxt;
            r_idle    <= w_idle_nxt;
            if (!r_first_seen && w_any_nxt) begin
                r_first_err_chan <= w_first_idx;
                r_first_seen     <= 1'b1;
            end else begin
                r_first_err_chan <= r_first_err_chan;
                r_first_seen     <= r_first_seen;
            end
        end
    end

    assign o_err_any        = r_err_any;
    assign o_first_err_chan = r_first_err_chan;
    assign o_idle           = r_idle;

endmodule

// File: tb/tb_cci_mpf_chan_checker.sv
// Scoreboard bench: a sticky and a pulsed checker watch the same bus; a
// channel-level reference model predicts both every cycle.
module tb_cci_mpf_chan_checker;
    localparam int MAXO  = 16;
    localparam int SLACK = 8;
    localparam int SAT   = 1023;

    logic clk;
    logic reset;

    cci_mpf_chan_checker_if #(.N_CHAN(2)) bus ();

    logic [19:0] s_out, p_out;
    logic [1:0]  s_ov, s_uf, s_af, p_ov, p_uf, p_af;
    logic        s_any, p_any, s_idle, p_idle;
    logic [2:0]  s_first, p_first;

    cci_mpf_chan_checker #(
        .N_CHAN(2), .CNT_W(10), .MAX_OUTSTANDING(MAXO), .ALMFULL_SLACK(SLACK), .STICKY_ERR(1)
    ) dut_s (
        .clk(clk), .reset(reset), .i_bus(bus),
        .o_outstanding(s_out), .o_err_overflow(s_ov), .o_err_underflow(s_uf),
        .o_err_almfull(s_af), .o_err_any(s_any), .o_first_err_chan(s_first), .o_idle(s_idle)
    );

    cci_mpf_chan_checker #(
        .N_CHAN(2), .CNT_W(10), .MAX_OUTSTANDING(MAXO), .ALMFULL_SLACK(SLACK), .STICKY_ERR(0)
    ) dut_p (
        .clk(clk), .reset(reset), .i_bus(bus),
        .o_outstanding(p_out), .o_err_overflow(p_ov), .o_err_underflow(p_uf),
        .o_err_almfull(p_af), .o_err_any(p_any), .o_first_err_chan(p_first), .o_idle(p_idle)
    );

    typedef struct packed {
        logic [9:0] c0;
        logic [9:0] c1;
        logic [1:0] ov_s, uf_s, af_s;
        logic [1:0] ov_p, uf_p, af_p;
        logic       any_s, any_p;
        logic [2:0] first;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: lines in flight, requests in the current
    // almost-full run, whether that run already reported, sticky history.
    int       m_cnt[2];
    int       m_ep_req[2];
    bit       m_ep_err[2];
    bit [1:0] m_ov, m_uf, m_af;
    bit       m_seen;
    int       m_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Apply one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input logic [1:0] tx, input logic [3:0] lines, input logic [1:0] af,
                        input logic [1:0] rx, input logic rst_n);
        exp_t     e;
        int       total, nxt;
        bit [1:0] of_e, uf_e, af_e;
        @(negedge clk);
        reset          = rst_n;
        bus.tx_valid   = tx;
        bus.tx_lines   = lines;
        bus.tx_almfull = af;
        bus.rx_valid   = rx;
        of_e = 2'b00; uf_e = 2'b00; af_e = 2'b00;
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_cnt[ch] = 0; m_ep_req[ch] = 0; m_ep_err[ch] = 1'b0;
            end
            m_ov = 2'b00; m_uf = 2'b00; m_af = 2'b00;
            m_seen = 1'b0; m_first = 0;
            e.idle = 1'b1;
        end else begin
            e.idle = (tx == 2'b00);
            for (int ch = 0; ch < 2; ch++) begin
                total    = m_cnt[ch] + (tx[ch] ? int'(lines[2*ch +: 2]) + 1 : 0);
                uf_e[ch] = rx[ch] && (total == 0);
                nxt      = (rx[ch] && total > 0) ? total - 1 : total;
                if (nxt > SAT) nxt = SAT;
                of_e[ch]  = (nxt > MAXO) && (m_cnt[ch] <= MAXO);
                m_cnt[ch] = nxt;
                if (nxt != 0) e.idle = 1'b0;
                if (!af[ch]) begin
                    m_ep_req[ch] = 0;
                    m_ep_err[ch] = 1'b0;
                end else begin
                    m_ep_req[ch] += int'(tx[ch]);
                    if (m_ep_req[ch] > SLACK && !m_ep_err[ch]) begin
                        af_e[ch] = 1'b1;
                        m_ep_err[ch] = 1'b1;
                    end
                end
            end
            m_ov |= of_e; m_uf |= uf_e; m_af |= af_e;
            if (!m_seen && ((of_e | uf_e | af_e) != 2'b00)) begin
                m_seen  = 1'b1;
                m_first = ((of_e[0] | uf_e[0] | af_e[0]) != 1'b0) ? 0 : 1;
            end
        end
        e.c0 = 10'(m_cnt[0]);
        e.c1 = 10'(m_cnt[1]);
        e.ov_s = m_ov; e.uf_s = m_uf; e.af_s = m_af;
        e.ov_p = of_e; e.uf_p = uf_e; e.af_p = af_e;
        e.any_s = ((m_ov | m_uf | m_af) != 2'b00);
        e.any_p = ((of_e | uf_e | af_e) != 2'b00);
        e.first = 3'(m_first);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUTs present outputs, compare with the queue head.
    initial begin
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                me = exp_q.pop_front();
                chk("out0_s",  32'(s_out[9:0]),   32'(me.c0));
                chk("out1_s",  32'(s_out[19:10]), 32'(me.c1));
                chk("out0_p",  32'(p_out[9:0]),   32'(me.c0));
                chk("out1_p",  32'(p_out[19:10]), 32'(me.c1));
                chk("ovf_s",   32'(s_ov),  32'(me.ov_s));
                chk("unf_s",   32'(s_uf),  32'(me.uf_s));
                chk("almf_s",  32'(s_af),  32'(me.af_s));
                chk("ovf_p",   32'(p_ov),  32'(me.ov_p));
                chk("unf_p",   32'(p_uf),  32'(me.uf_p));
                chk("almf_p",  32'(p_af),  32'(me.af_p));
                chk("any_s",   32'(s_any), 32'(me.any_s));
                chk("any_p",   32'(p_any), 32'(me.any_p));
                chk("first_s", 32'(s_first), 32'(me.first));
                chk("first_p", 32'(p_first), 32'(me.first));
                chk("idle_s",  32'(s_idle), 32'(me.idle));
                chk("idle_p",  32'(p_idle), 32'(me.idle));
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit %0t reached", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        logic [1:0] tx, rx, af_r;
        logic [3:0] ln;
        logic       rn;
        reset = 1'b0;
        bus.tx_valid = 2'b00; bus.tx_lines = 4'b0000;
        bus.tx_almfull = 2'b00; bus.rx_valid = 2'b00;

        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        // 4-line request on ch0, drained one line per cycle.
        step(2'b01, 4'b0011, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b00, 4'b0000, 2'b00, 2'b01, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        // ch1: request and response net out at zero, then a bare response.
        step(2'b10, 4'b0000, 2'b00, 2'b10, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b10, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        // Almost-full slack on ch0: 10 requests, release, fresh 9.
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) step(2'b01, 4'b0000, 2'b01, 2'b01, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 9; i++) step(2'b01, 4'b0000, 2'b01, 2'b01, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        // Overflow: five 4-line requests, then quiet cycles.
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b01, 4'b0011, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        // Simultaneous underflow on both channels, then a later ch1 error.
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        step(2'b00, 4'b0000, 2'b00, 2'b11, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b10, 1'b1);
        // Reset with 7 outstanding and sticky errors, then a stale response.
        step(2'b01, 4'b0011, 2'b00, 2'b00, 1'b1);
        step(2'b01, 4'b0010, 2'b00, 2'b00, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        step(2'b00, 4'b0000, 2'b00, 2'b01, 1'b1);
        // Saturation on ch1.
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 260; i++) step(2'b10, 4'b1100, 2'b00, 2'b00, 1'b1);
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b0);

        // Randomized traffic with persistent almost-full episodes.
        af_r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                tx[ch] = ($urandom_range(0, 99) < 30);
                rx[ch] = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 99) < 4) af_r[ch] = ~af_r[ch];
            end
            ln = 4'($urandom_range(0, 15));
            rn = ($urandom_range(0, 499) != 0);
            step(tx, ln, af_r, rx, rn);
        end
        step(2'b00, 4'b0000, 2'b00, 2'b00, 1'b1);

        @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
